// File: rtl/clk_switch_ctrl.sv
// Break-before-make clock source switch controller: drives one-hot clock enables
// for N global buffers and inserts a programmable all-off gap on every change.
module clk_switch_ctrl #(
  parameter int NUM_CLKS    = 4,
  parameter int SEL_W       = $clog2(NUM_CLKS),
  parameter int DEAD_CYCLES = 8,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [SEL_W-1:0]    sel_req,
  input  logic                sel_valid,
  output logic                sel_ready,
  output logic [NUM_CLKS-1:0] clk_ce,
  output logic [SEL_W-1:0]    active_sel,
  output logic                busy,
  output logic                switch_done,
  output logic                sel_err
);

  localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
  localparam int MAP_W = 1 << SEL_W;
  // Bit i is set when index i names a real clock source.
  localparam logic [MAP_W-1:0] VALID_MAP = {MAP_W{1'b1}} >> (MAP_W - NUM_CLKS);
  localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_SEL);

  typedef enum logic {RUN, GAP} state_t;

  state_t           state;
  logic [SEL_W-1:0] target;
  logic [CNT_W-1:0] dead_cnt;

  function automatic logic [NUM_CLKS-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_CLKS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign sel_ready = (state == RUN);

  // The counter is loaded with DEAD_CYCLES on accept and the new enable is
  // raised on the edge where it reads 1, giving exactly DEAD_CYCLES dark cycles.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= RUN;
      clk_ce      <= onehot(DEF_SEL);
      active_sel  <= DEF_SEL;
      target      <= DEF_SEL;
      dead_cnt    <= '0;
      busy        <= 1'b0;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
      case (state)
        RUN: begin
          if (sel_valid) begin
            if (!VALID_MAP[sel_req]) begin
              sel_err <= 1'b1;
            end else if (sel_req == active_sel) begin
              switch_done <= 1'b1;
            end else begin
              target   <= sel_req;
              clk_ce   <= '0;
              dead_cnt <= CNT_W'(DEAD_CYCLES);
              busy     <= 1'b1;
              state    <= GAP;
            end
          end
        end
        GAP: begin
          if (dead_cnt == CNT_W'(1)) begin
            clk_ce      <= onehot(target);
            active_sel  <= target;
            switch_done <= 1'b1;
            busy        <= 1'b0;
            state       <= RUN;
          end else begin
            dead_cnt <= dead_cnt - CNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed checks on a 4-source/8-gap instance and a
// randomised run on a 5-source/1-gap instance against a cycle-timeline model.
module tb_clk_switch_ctrl;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Instance A: NUM_CLKS=4, DEAD_CYCLES=8, DEFAULT_SEL=2
  logic       a_reset, a_valid, a_ready, a_busy, a_done, a_err;
  logic [1:0] a_req, a_active;
  logic [3:0] a_ce;

  clk_switch_ctrl #(.NUM_CLKS(4), .DEAD_CYCLES(8), .DEFAULT_SEL(2)) dut_a (
    .aclk(aclk), .areset(a_reset), .sel_req(a_req), .sel_valid(a_valid),
    .sel_ready(a_ready), .clk_ce(a_ce), .active_sel(a_active), .busy(a_busy),
    .switch_done(a_done), .sel_err(a_err)
  );

  // Instance B: NUM_CLKS=5 so out-of-range indices 5..7 are encodable
  localparam int B_N = 5;
  localparam int B_D = 1;
  logic       b_reset, b_valid, b_ready, b_busy, b_done, b_err;
  logic [2:0] b_req, b_active;
  logic [4:0] b_ce;

  clk_switch_ctrl #(.NUM_CLKS(B_N), .DEAD_CYCLES(B_D), .DEFAULT_SEL(0)) dut_b (
    .aclk(aclk), .areset(b_reset), .sel_req(b_req), .sel_valid(b_valid),
    .sel_ready(b_ready), .clk_ce(b_ce), .active_sel(b_active), .busy(b_busy),
    .switch_done(b_done), .sel_err(b_err)
  );

  task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] req);
    a_valid = valid;
    a_req   = req;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkA(input string tag, input logic [3:0] ce, input logic [1:0] act,
                        input logic rdy, input logic bsy, input logic dn);
    checkOutput({tag, "_ce"},     a_ce,     ce);
    checkOutput({tag, "_active"}, a_active, act);
    checkOutput({tag, "_ready"},  a_ready,  rdy);
    checkOutput({tag, "_busy"},   a_busy,   bsy);
    checkOutput({tag, "_done"},   a_done,   dn);
    checkOutput({tag, "_err"},    a_err,    1'b0);
  endtask

  // Timeline model for instance B: a switch accepted at cycle n is dark until
  // cycle n+D and shows the new source at end_cyc = n+D+1.
  int         m_cyc;
  int         m_active;
  int         m_target;
  int         m_end_cyc;
  bit         m_pending;
  bit         m_done, m_err;

  initial begin
    a_reset = 1'b1; a_valid = 1'b0; a_req = '0;
    b_reset = 1'b1; b_valid = 1'b0; b_req = '0;
    tick(); tick();
    a_reset = 1'b0;
    b_reset = 1'b0;
    tick();

    checkA("reset", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);

    // Plain switch to source 1
    applyStimulus(1'b1, 2'd1);
    tick();
    applyStimulus(1'b0, 2'd0);
    for (int k = 1; k <= 8; k++) begin
      checkA($sformatf("gap1_%0d", k), 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
      tick();
    end
    checkA("sw1_end", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1);
    tick();
    checkA("sw1_after", 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0);

    // Requests during GAP must be ignored; only source 3 is enabled
    applyStimulus(1'b1, 2'd3);
    tick();
    for (int k = 1; k <= 8; k++) begin
      checkA($sformatf("gap2_%0d", k), 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
      applyStimulus(k < 8, 2'(k));
      tick();
    end
    checkA("sw2_end", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);

    // Same-source requests back to back: done each cycle, enable never drops
    applyStimulus(1'b1, 2'd3);
    tick();
    checkA("same1", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 2'd0);
    checkA("same2", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    tick();
    checkA("same_idle", 4'b1000, 2'd3, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a switch discards the target
    applyStimulus(1'b1, 2'd0);
    tick();
    applyStimulus(1'b0, 2'd0);
    checkA("rgap1", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
    tick();
    checkA("rgap2", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
    checkA("rgap_rst", 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkA($sformatf("rgap_post%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0);
    end

    // Randomised run on instance B
    m_cyc = 0; m_active = 0; m_pending = 0; m_done = 0; m_err = 0;
    m_target = 0; m_end_cyc = 0;
    begin
      logic [4:0] prev_ce;
      logic       prev_rst;
      logic [4:0] exp_ce;
      prev_ce  = b_ce;
      prev_rst = 1'b0;
      for (int i = 0; i < 12000; i++) begin
        exp_ce = m_pending ? 5'b0 : 5'(1 << m_active);
        checkOutput("b_ce",     b_ce,     exp_ce);
        checkOutput("b_active", b_active, m_active);
        checkOutput("b_ready",  b_ready,  !m_pending);
        checkOutput("b_busy",   b_busy,   m_pending);
        checkOutput("b_done",   b_done,   m_done);
        checkOutput("b_err",    b_err,    m_err);
        checkOutput("b_onehot", ($countones(b_ce) <= 1), 1);
        if (!prev_rst)
          checkOutput("b_adjacent", (prev_ce == 0 || b_ce == 0 || prev_ce == b_ce), 1);
        prev_ce = b_ce;

        b_valid = ($urandom_range(0, 3) != 0);
        b_req   = 3'($urandom_range(0, 7));
        b_reset = m_pending && ($urandom_range(0, 15) == 0);
        prev_rst = b_reset;

        m_done = 0;
        m_err  = 0;
        if (b_reset) begin
          m_active  = 0;
          m_pending = 0;
        end else if (m_pending) begin
          if (m_cyc + 1 == m_end_cyc) begin
            m_active  = m_target;
            m_pending = 0;
            m_done    = 1;
          end
        end else if (b_valid) begin
          if (int'(b_req) >= B_N)           m_err = 1;
          else if (int'(b_req) == m_active) m_done = 1;
          else begin
            m_pending = 1;
            m_target  = int'(b_req);
            m_end_cyc = m_cyc + 1 + B_D;
          end
        end
        m_cyc++;
        tick();
        b_reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
